// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types, sizes and operation-decode helpers for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_XLEN      = 32;
  localparam int MDU_DIV_ITERS = 32;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU, MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
  } risk_mdu_e;

  typedef struct packed {
    logic      enable;
    risk_mdu_e operation;
  } mdu_control_t;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} mdu_state_e;

  function automatic logic is_mdu_div(risk_mdu_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_mdu_rem(risk_mdu_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_mdu_signed_op1(risk_mdu_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic is_mdu_signed_op2(risk_mdu_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on unsigned magnitudes
module mdu_div_step import mdu_pkg::*; (
  input  logic [MDU_XLEN-1:0] rem_i,
  input  logic [MDU_XLEN-1:0] quo_i,
  input  logic [MDU_XLEN-1:0] div_i,
  output logic [MDU_XLEN-1:0] rem_o,
  output logic [MDU_XLEN-1:0] quo_o
);
  logic [MDU_XLEN:0] sh;
  logic              ge;

  // shift the next dividend bit into the partial remainder and subtract if it fits
  always_comb begin
    sh    = {rem_i, quo_i[MDU_XLEN-1]};
    ge    = sh >= {1'b0, div_i};
    rem_o = ge ? sh[MDU_XLEN-1:0] - div_i : sh[MDU_XLEN-1:0];
    quo_o = {quo_i[MDU_XLEN-2:0], ge};
  end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MUL/DIV/REM sequencer holding its result on a valid/ready handshake.
// Define MDU_DIV_EARLY_OUT_EN to skip the divide loop for divide-by-zero and signed overflow.
module mdu_sequencer import mdu_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  mdu_control_t        i_mdu_control,
  input  logic [MDU_XLEN-1:0] i_op1,
  input  logic [MDU_XLEN-1:0] i_op2,
  input  logic [4:0]          i_rd,
  input  logic                i_flush,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [MDU_XLEN-1:0] o_result,
  output logic [4:0]          o_rd
);
  localparam logic [MDU_XLEN-1:0] MIN_NEG = {1'b1, {(MDU_XLEN-1){1'b0}}};

  mdu_state_e            state_q;
  risk_mdu_e             op_q, op_i;
  logic [MDU_XLEN-1:0]   op1_q, op2_q, rem_q, quo_q, dvs_q, res_q;
  logic [MDU_XLEN-1:0]   rem_d, quo_d, q_fix, r_fix;
  logic [2*MDU_XLEN-1:0] prod_d;
  logic [4:0]            rd_q, cnt_q;
  logic                  dz, ovf, early;

  assign op_i     = i_mdu_control.operation;
  assign o_ready  = state_q == IDLE;
  assign o_busy   = state_q != IDLE;
  assign o_valid  = state_q == DONE;
  assign o_result = res_q;
  assign o_rd     = rd_q;

`ifdef MDU_DIV_EARLY_OUT_EN
  assign early = is_mdu_div(op_i) & ((i_op2 == '0) | (is_mdu_signed_op1(op_i) & (i_op1 == MIN_NEG) & (&i_op2)));
`else
  assign early = 1'b0;
`endif

  mdu_div_step u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .div_i(dvs_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );

  // extended product and the sign/special-case corrected divide results
  always_comb begin
    prod_d = {{MDU_XLEN{is_mdu_signed_op1(op_q) & op1_q[MDU_XLEN-1]}}, op1_q} *
             {{MDU_XLEN{is_mdu_signed_op2(op_q) & op2_q[MDU_XLEN-1]}}, op2_q};
    dz     = op2_q == '0;
    ovf    = is_mdu_signed_op1(op_q) & (op1_q == MIN_NEG) & (&op2_q);
    q_fix  = dz ? '1 : ovf ? MIN_NEG :
             (is_mdu_signed_op1(op_q) & (op1_q[MDU_XLEN-1] ^ op2_q[MDU_XLEN-1])) ? -quo_q : quo_q;
    r_fix  = dz ? op1_q : ovf ? '0 : (is_mdu_signed_op1(op_q) & op1_q[MDU_XLEN-1]) ? -rem_q : rem_q;
  end

  // sequencer FSM: accept, multiply or iterate the divider, correct, then hold until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MDU_MUL;
      op1_q   <= '0;
      op2_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (i_valid & i_mdu_control.enable) begin
          op_q    <= op_i;
          op1_q   <= i_op1;
          op2_q   <= i_op2;
          rd_q    <= i_rd;
          rem_q   <= '0;
          quo_q   <= (is_mdu_signed_op1(op_i) & i_op1[MDU_XLEN-1]) ? -i_op1 : i_op1;
          dvs_q   <= (is_mdu_signed_op2(op_i) & i_op2[MDU_XLEN-1]) ? -i_op2 : i_op2;
          cnt_q   <= '0;
          state_q <= is_mdu_div(op_i) ? (early ? FIX : DIV) : MUL;
        end
        MUL: begin
          res_q   <= (op_q == MDU_MUL) ? prod_d[MDU_XLEN-1:0] : prod_d[2*MDU_XLEN-1:MDU_XLEN];
          state_q <= DONE;
        end
        DIV: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q + 5'd1;
          state_q <= (cnt_q == 5'(MDU_DIV_ITERS - 1)) ? FIX : DIV;
        end
        FIX: begin
          res_q   <= is_mdu_rem(op_q) ? r_fix : q_fix;
          state_q <= DONE;
        end
        DONE: if (i_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vectors checked against an arithmetic reference model every cycle
module tb_mdu_sequencer;
  import mdu_pkg::*;

`ifdef MDU_DIV_EARLY_OUT_EN
  localparam int SP_LAT = 2;
`else
  localparam int SP_LAT = 34;
`endif

  logic         clk = 1'b0, rst_n = 1'b1, i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  mdu_control_t ctl = '0;
  logic [31:0]  i_op1 = '0, i_op2 = '0;
  logic [4:0]   i_rd = '0;
  logic         o_ready, o_busy, o_valid;
  logic [31:0]  o_result;
  logic [4:0]   o_rd;

  int checks = 0, failures = 0;

  bit          m_busy = 1'b0, m_valid = 1'b0, m_clean = 1'b1;
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_mdu_control(ctl),
    .i_op1(i_op1), .i_op2(i_op2), .i_rd(i_rd), .i_flush(i_flush),
    .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(risk_mdu_e op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    if (op == MDU_MUL || op == MDU_MULH) p = sa * sb;
    if (op == MDU_MULHSU) p = sa * longint'(ub);
    if (op == MDU_MULHU) p = ua * ub;
    case (op)
      MDU_MUL: return p[31:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: return p[63:32];
      MDU_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(sa / sb);
      end
      MDU_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(sa % sb);
      end
      MDU_DIVU: begin
        if (b == 0) return 32'hFFFFFFFF;
        return 32'(ua / ub);
      end
      MDU_REMU: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(risk_mdu_e op, logic [31:0] a, logic [31:0] b);
    if (!(op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU})) return 2;
    if (b == 0 || (op inside {MDU_DIV, MDU_REM} && a == 32'h80000000 && b == 32'hFFFFFFFF)) return SP_LAT;
    return 34;
  endfunction

  // reference model: a countdown of edges to the result, then hold until consumed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0; m_res <= '0; m_rd <= '0; m_clean <= 1'b1;
    end else if (i_flush) begin
      m_busy <= 1'b0; m_valid <= 1'b0;
    end else if (m_valid) begin
      if (i_ready) begin m_valid <= 1'b0; m_busy <= 1'b0; end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (i_valid && ctl.enable) begin
      m_busy  <= 1'b1;
      m_left  <= ref_lat(ctl.operation, i_op1, i_op2) - 1;
      m_res   <= ref_res(ctl.operation, i_op1, i_op2);
      m_rd    <= i_rd;
      m_clean <= 1'b0;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    check("handshake", 64'({o_ready, o_busy, o_valid}), 64'({!m_busy, m_busy, m_valid}));
    if (m_valid) begin
      check("result", 64'(o_result), 64'(m_res));
      check("rd", 64'(o_rd), 64'(m_rd));
    end
    if (m_clean) check("reset_outputs", 64'({o_result, o_rd}), 64'(0));
  end

  task automatic start(input risk_mdu_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    i_valid = 1'b1; ctl.enable = 1'b1; ctl.operation = op; i_op1 = a; i_op2 = b; i_rd = rd;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input risk_mdu_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    int n;
    check({name, " model"}, 64'(ref_res(op, a, b)), 64'(exp_res));
    start(op, a, b, rd);
    n = 1;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " value"}, 64'(o_result), 64'(exp_res));
    check({name, " dest"}, 64'(o_rd), 64'(rd));
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({o_ready, o_busy, o_valid, o_result, o_rd}), 64'({1'b1, 1'b0, 1'b0, 32'h0, 5'h0}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7x-3", MDU_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 2);
    run_op("mulhu_max", MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 2);
    run_op("mulh_min", MDU_MULH, 32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 2);
    run_op("mulhsu_m1", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 2);
    run_op("div_-7/2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34);
    run_op("rem_-7/2", MDU_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34);
    run_op("divu_100/7", MDU_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 34);
    run_op("remu_100/7", MDU_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 34);
    run_op("div_7/-2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 34);
    run_op("rem_7/-2", MDU_REM, 32'd7, 32'hFFFFFFFE, 5'd17, 32'd1, 34);
    run_op("divu_min/max", MDU_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0, 34);
    run_op("div_5/0", MDU_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, SP_LAT);
    run_op("rem_5/0", MDU_REM, 32'd5, 32'd0, 5'd10, 32'd5, SP_LAT);
    run_op("rem_-5/0", MDU_REM, 32'hFFFFFFFB, 32'd0, 5'd11, 32'hFFFFFFFB, SP_LAT);
    run_op("divu_5/0", MDU_DIVU, 32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, SP_LAT);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, SP_LAT);
    run_op("rem_ovf", MDU_REM, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, SP_LAT);

    i_valid = 1'b1; ctl.enable = 1'b0; ctl.operation = MDU_MUL;
    repeat (3) @(posedge clk);
    #1;
    check("enable_low_ignored", 64'(o_busy), 64'(0));
    i_valid = 1'b0;

    start(MDU_MUL, 32'd6, 32'd7, 5'd20);
    @(posedge clk); #1;
    i_valid = 1'b1; ctl.enable = 1'b1; ctl.operation = MDU_DIV; i_op1 = 32'd9; i_op2 = 32'd3; i_rd = 5'd21;
    repeat (10) begin
      @(posedge clk); #1;
      check("backpressure_hold", 64'({o_valid, o_ready, o_rd, o_result}), 64'({1'b1, 1'b0, 5'd20, 32'd42}));
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("backpressure_no_accept", 64'(o_busy), 64'(0));

    start(MDU_DIVU, 32'd1000, 32'd3, 5'd22);
    repeat (9) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_div_idle", 64'({o_busy, o_valid, o_ready}), 64'(3'b001));
    repeat (40) @(posedge clk);
    #1;
    run_op("mul_3x4", MDU_MUL, 32'd3, 32'd4, 5'd23, 32'd12, 2);

    start(MDU_MUL, 32'd2, 32'd5, 5'd24);
    @(posedge clk); #1;
    i_ready = 1'b1; i_flush = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0; i_flush = 1'b0;
    check("flush_done", 64'({o_busy, o_valid}), 64'(0));

    i_valid = 1'b1; ctl.enable = 1'b1; ctl.operation = MDU_MUL; i_flush = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_beats_accept", 64'(o_busy), 64'(0));

    start(MDU_DIVU, 32'd100, 32'd7, 5'd25);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({o_ready, o_busy, o_valid, o_result, o_rd}), 64'({1'b1, 1'b0, 1'b0, 32'h0, 5'h0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("divu_after_reset", MDU_DIVU, 32'd100, 32'd7, 5'd26, 32'd14, 34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
